// File: rtl/imem_load_ctrl_pkg.sv
// Shared constants, FSM state type and state decode helper for the
// instruction-RAM load controller. IMEM_LOAD_CHECKSUM_EN adds the CHK state.
package imem_pkg;

  localparam int unsigned WORD_W = 22;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DEPTH  = 101;
  localparam int unsigned IDX_W  = 7;

  // MOVER R0, #0 -- harmless filler fed to the core while stalled or out of range
  localparam logic [WORD_W-1:0] IMEM_NOP = 22'b1001101000000000000000;

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    B2,
    B1,
    B0,
    WR,
    DONE,
    ERR
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    CHK
`endif
  } state_e;

  // States in which the loader byte stream is being consumed
  function automatic logic takes_byte(input state_e s);
    case (s)
      LEN, B2, B1, B0: return 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
      CHK:             return 1'b1;
`endif
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Byte-serial loader stream (valid/ready handshake).
interface imem_load_ctrl_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);
endinterface

// File: rtl/imem_load_ctrl_assembler.sv
// imem_word_assembler: three-byte shift register building one instruction
// word, plus a running XOR of every data byte of the current load.
module imem_word_assembler #(
  parameter int unsigned WORD_W = imem_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic [7:0]        csum_o
);

  logic [23:0] sr_q;
  logic [7:0]  csum_q;
  logic        unused_hi;

  // Shift in accepted data bytes MSB first; checksum restarts on each load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= '0;
      csum_q <= '0;
    end else begin
      if (shift_i) begin
        sr_q <= {sr_q[15:0], byte_i};
      end
      if (clr_i) begin
        csum_q <= '0;
      end else if (shift_i) begin
        csum_q <= csum_q ^ byte_i;
      end
    end
  end

  // Top bits of the first byte are dropped: the word is only WORD_W wide
  assign word_o    = sr_q[WORD_W-1:0];
  assign csum_o    = csum_q;
  assign unused_hi = ^sr_q[23:WORD_W];

endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: fetch passthrough for the instruction RAM plus a byte-serial
// loader that stalls the core, writes words from index 0 upward and releases it.
// Optional IMEM_LOAD_CHECKSUM_EN: a trailing XOR checksum byte is verified.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned WORD_W = imem_pkg::WORD_W,
  parameter int unsigned ADDR_W = imem_pkg::ADDR_W,
  parameter int unsigned DEPTH  = imem_pkg::DEPTH,
  parameter int unsigned IDX_W  = imem_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [WORD_W-1:0] cpu_instr,
  output logic              cpu_stall,
  input  logic              load_req,
  imem_load_ctrl_if.slave   ld,
  output logic [IDX_W-1:0]  mem_raddr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              load_done,
  output logic              load_err,
  output logic [IDX_W-1:0]  words_loaded
);

  localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);
  localparam logic [7:0]        DEPTH_B   = 8'(DEPTH);
  localparam logic [IDX_W-1:0]  ONE_IDX   = IDX_W'(1);

  state_e            state_q, state_d;
  logic              cpu_stall_q, byte_ready_q, mem_we_q, load_done_q, load_err_q;
  logic [IDX_W-1:0]  waddr_q, words_q, n_q;
  logic              accept, start, asm_shift;
  logic [WORD_W-1:0] asm_word;
  logic [7:0]        asm_csum;
  logic              unused_addr;

  assign accept    = ld.byte_valid & byte_ready_q;
  assign start     = (state_q == IDLE) & load_req;
  assign asm_shift = accept & ((state_q == B2) | (state_q == B1) | (state_q == B0));

  imem_word_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start),
    .shift_i (asm_shift),
    .byte_i  (ld.byte_data),
    .word_o  (asm_word),
    .csum_o  (asm_csum)
  );

  // Next-state decode; outputs below are registered from state_d so they
  // line up with the state they belong to
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load_req) state_d = LEN;
      LEN: begin
        if (accept) begin
          if ((ld.byte_data == 8'd0) || (ld.byte_data > DEPTH_B)) state_d = ERR;
          else                                                    state_d = B2;
        end
      end
      B2: if (accept) state_d = B1;
      B1: if (accept) state_d = B0;
      B0: if (accept) state_d = WR;
      WR: begin
        if ((words_q + ONE_IDX) == n_q) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = B2;
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (ld.byte_data == asm_csum) state_d = DONE;
          else                          state_d = ERR;
        end
      end
`endif
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, registered control outputs and load bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cpu_stall_q  <= 1'b0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      waddr_q      <= '0;
      words_q      <= '0;
      n_q          <= '0;
    end else begin
      state_q      <= state_d;
      cpu_stall_q  <= (state_d != IDLE);
      byte_ready_q <= takes_byte(state_d);
      mem_we_q     <= (state_d == WR);
      load_done_q  <= (state_d == DONE);
      if (start) begin
        load_err_q <= 1'b0;
        words_q    <= '0;
        waddr_q    <= '0;
      end else begin
        if (state_d == ERR) load_err_q <= 1'b1;
        if (state_q == WR) begin
          waddr_q <= waddr_q + ONE_IDX;
          words_q <= words_q + ONE_IDX;
        end
      end
      if ((state_q == LEN) && accept) n_q <= ld.byte_data[IDX_W-1:0];
    end
  end

  // Fetch path: full word index is range-checked, not just the RAM index bits
  always_comb begin
    cpu_instr = mem_rdata;
    if (cpu_stall_q || (cpu_addr[ADDR_W-1:2] >= DEPTH_IDX)) cpu_instr = IMEM_NOP;
  end

  assign mem_raddr     = cpu_addr[IDX_W+1:2];
  assign unused_addr   = ^cpu_addr[1:0];
  assign cpu_stall     = cpu_stall_q;
  assign ld.byte_ready = byte_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_waddr     = waddr_q;
  assign mem_wdata     = asm_word;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign words_loaded  = words_q;

`ifndef IMEM_LOAD_CHECKSUM_EN
  logic unused_csum;
  assign unused_csum = ^asm_csum;
`endif

endmodule
